spi_reg_sequencer: RTL and testbench
====================================

# spi_reg_sequencer

Sequencer that walks a configuration table of NUM_REGS register words and writes each one to an external device as a single chip-select frame. It fetches each word from a synchronous table read port and serialises it MSB byte first into the byte-level SPI master-with-CS handshake. It sits between radar control logic (start/abort) and the SPI CS master, and is used for PLL/synthesizer programming ahead of each sweep.

## Interface

Parameters:

- NUM_REGS, 8: number of table entries written per sequence (≥1).
- BYTES_PER_REG, 3: bytes per register word and per CS frame (≥1).
- MAX_BYTES_PER_CS, 3: must match the SPI CS master; must be ≥ BYTES_PER_REG.
- GAP_CLKS, 4: extra idle i_Clk cycles between the end of one frame and the next fetch (0 allowed).

Ports:

- i_Clk, in, 1: system clock.
- i_Rst_L, in, 1: reset, asynchronous, active-low.
- i_Start, in, 1: pulse; begins a sequence when idle.
- i_Abort, in, 1: pulse; stops the sequence at the next frame boundary.
- o_Busy, out, 1: high from start acceptance until o_Done or o_Aborted.
- o_Done, out, 1: one-cycle pulse after the last frame completes.
- o_Aborted, out, 1: one-cycle pulse when an abort completes.
- o_Reg_Addr, out, $clog2(NUM_REGS): table read address. The table has 1-cycle read latency.
- i_Reg_Data, in, 8*BYTES_PER_REG: table read data.
- o_TX_Count, out, $clog2(MAX_BYTES_PER_CS+1): bytes per CS frame. Constant BYTES_PER_REG.
- o_TX_Byte, out, 8: byte to SPI master.
- o_TX_DV, out, 1: one-cycle byte-valid pulse.
- i_TX_Ready, in, 1: SPI master ready.

## Operation

- States: IDLE, FETCH, LOAD, SEND, HOLD, WAIT_RDY, GAP, DONE.
- **IDLE:** on i_Start=1 and i_Abort=0:
  - index←0, o_Busy←1, go to FETCH.
  - i_Start while busy is ignored.
- **FETCH:** o_Reg_Addr=index. Next cycle go to LOAD.
- **LOAD:** latch i_Reg_Data into the shift register, byte counter←BYTES_PER_REG, go to SEND.
- **SEND:** when i_TX_Ready=1:
  - o_TX_Byte←shift[MSB byte], o_TX_DV←1 for one cycle.
  - shift left 8, decrement the byte counter, go to HOLD.
- **HOLD:** one-cycle holdoff; i_TX_Ready is ignored here (the master deasserts it one cycle after DV).
  - Byte counter ≠0: back to SEND.
  - Byte counter =0: go to WAIT_RDY.
- **WAIT_RDY:** wait for i_TX_Ready=1, which the master returns only after CS deassertion and its CS-inactive time. Then go to GAP.
- **GAP:** count GAP_CLKS cycles. Then:
  - index = NUM_REGS-1: go to DONE.
  - Abort latched: go to IDLE and pulse o_Aborted.
  - Otherwise: index+1, go to FETCH.
- **DONE:** pulse o_Done, clear o_Busy, go to IDLE.
- **Abort:**
  - i_Abort in any busy state sets a sticky flag.
  - A frame is never truncated; the abort takes effect in GAP.
  - If the flag is set when the last register completes, o_Done wins and the flag is cleared.

## Timing

- Reset values: o_Busy=0, o_Done=0, o_Aborted=0, o_TX_DV=0, o_TX_Byte=0, o_Reg_Addr=0, o_TX_Count=BYTES_PER_REG, state=IDLE, abort flag=0, counters=0.
- Reset mid-frame drops o_TX_DV immediately. The SPI master shares the reset, so no partial frame resumes.
- i_Start accepted on edge N gives o_Reg_Addr=0 valid in N+1 and the first possible o_TX_DV in N+3.
- Consecutive o_TX_DV pulses within a frame are at least 2 cycles apart.
- o_TX_Byte is stable while o_TX_DV=1 and holds its value afterwards.
- The index counter never wraps: it saturates at NUM_REGS-1 and resets to 0 only in IDLE on start.
- Simultaneous i_Start and i_Abort in IDLE: the start is rejected.

## Configuration

- **SPI_SEQ_RX_CAPTURE_EN defined:** adds the following ports.
  - i_RX_DV (in, 1), i_RX_Byte (in, 8).
  - o_RX_Word (out, 8*BYTES_PER_REG, reset 0).
  - o_RX_Valid (out, 1, reset 0).
  - Each i_RX_DV shifts i_RX_Byte into the LSB of the capture register.
  - On entry to GAP, o_RX_Word←capture and o_RX_Valid pulses for one cycle. The capture register clears in LOAD.
- **Undefined:** these ports and the capture logic do not exist; MISO data is ignored.

## Structure

- Package spi_seq_pkg holds:
  - the state enum type;
  - localparam width helpers (index width, TX-count width);
  - a parameter-check note on the MAX_BYTES_PER_CS ≥ BYTES_PER_REG constraint.
- Sub-module spi_seq_gap_timer: a loadable down-counter with start/expired outputs, used for GAP. It is also reusable for post-sequence lock-wait delays.

## Test plan

- **Nominal sequence:** NUM_REGS=3, BYTES_PER_REG=3, table {0x123456, 0xABCDEF, 0x000001}, SPI master model with CS.
  - Bytes 12 34 56 / AB CD EF / 00 00 01 across three separate CS-low frames.
  - o_TX_Count=3 throughout; one o_Done; o_Busy low afterwards.
- **Abort at frame boundary:** i_Abort pulsed during byte 2 of register 0.
  - Register 0 completes fully, no register 1 bytes are sent.
  - o_Aborted pulses once, o_Done never pulses.
- **Start while busy and start+abort:** i_Start re-pulsed mid-sequence, then i_Start and i_Abort together in IDLE.
  - The mid-sequence start has no effect: still exactly 9 bytes total.
  - The simultaneous pulse leaves the block in IDLE, o_Busy=0.
- **Reset mid-frame:** i_Rst_L low during o_TX_DV of byte 2.
  - All outputs reach reset values asynchronously.
  - A fresh i_Start restarts at register 0, byte 0x12.
- **GAP_CLKS=0 and slow ready:** ready held low 50 cycles after each byte.
  - No DV is issued while ready is low.
  - Exactly one DV per ready assertion; DV spacing ≥2.
- **SPI_SEQ_RX_CAPTURE_EN:** MISO model returns 0xA5 0x5A 0xC3 for register 1.
  - o_RX_Word=0xA55AC3 with one o_RX_Valid pulse on GAP entry.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types and width helpers for the SPI register sequencer.
// MAX_BYTES_PER_CS must be >= BYTES_PER_REG: the CS master frames on o_TX_Count.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_HOLD,
        ST_WAIT_RDY,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int unsigned BYTE_W = 8;

    // Address width for n table entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_seq_gap_timer.sv
// Loadable down-counter; expired is high on the cycle the count reaches zero.
// Used for the inter-frame gap, also suitable for post-sequence lock waits.
module spi_seq_gap_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic             active;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign expired = active && (count == '0);

endmodule

// File: rtl/spi_reg_sequencer.sv
// Walks a NUM_REGS table and writes each word MSB byte first as one SPI CS frame.
// Define SPI_SEQ_RX_CAPTURE_EN to add MISO capture ports (o_RX_Word / o_RX_Valid).
//   state    | meaning
//   IDLE     | waiting for i_Start
//   FETCH    | table address presented
//   LOAD     | table data latched into shift register
//   SEND     | waiting for ready, then issue one byte
//   HOLD     | one-cycle holdoff while the master drops ready
//   WAIT_RDY | frame sent, waiting for CS release
//   GAP      | inter-frame idle, abort/done decision
//   DONE     | o_Done pulse
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_REGS         = 8,
    parameter int unsigned BYTES_PER_REG    = 3,
    parameter int unsigned MAX_BYTES_PER_CS = 3,
    parameter int unsigned GAP_CLKS         = 4
) (
    input  logic                                   i_Clk,
    input  logic                                   i_Rst_L,
    input  logic                                   i_Start,
    input  logic                                   i_Abort,
    output logic                                   o_Busy,
    output logic                                   o_Done,
    output logic                                   o_Aborted,
    output logic [idx_width(NUM_REGS)-1:0]         o_Reg_Addr,
    input  logic [BYTE_W*BYTES_PER_REG-1:0]        i_Reg_Data,
    output logic [cnt_width(MAX_BYTES_PER_CS)-1:0] o_TX_Count,
    output logic [BYTE_W-1:0]                      o_TX_Byte,
    output logic                                   o_TX_DV,
    input  logic                                   i_TX_Ready
`ifdef SPI_SEQ_RX_CAPTURE_EN
    ,
    input  logic                                   i_RX_DV,
    input  logic [BYTE_W-1:0]                      i_RX_Byte,
    output logic [BYTE_W*BYTES_PER_REG-1:0]        o_RX_Word,
    output logic                                   o_RX_Valid
`endif
);

    localparam int unsigned DATA_W = BYTE_W * BYTES_PER_REG;
    localparam int unsigned IDX_W  = idx_width(NUM_REGS);
    localparam int unsigned BC_W   = cnt_width(BYTES_PER_REG);
    localparam int unsigned TXC_W  = cnt_width(MAX_BYTES_PER_CS);
    localparam int unsigned GAP_W  = cnt_width(GAP_CLKS);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    index;
    logic [DATA_W-1:0]   shift;
    logic [BC_W-1:0]     byte_cnt;
    logic                abort_flag;
    logic                start_acc, load, fire, gap_start, inc_idx, abort_done;
    logic                gap_expired;
    logic                last_reg;

    assign last_reg   = (index == IDX_W'(NUM_REGS - 1));
    assign o_Reg_Addr = index;
    assign o_TX_Count = TXC_W'(BYTES_PER_REG);
    assign o_Busy     = (state != ST_IDLE);
    assign o_Done     = (state == ST_DONE);

    spi_seq_gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .start    (gap_start),
        .load_val (GAP_W'(GAP_CLKS)),
        .expired  (gap_expired)
    );

    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        load       = 1'b0;
        fire       = 1'b0;
        gap_start  = 1'b0;
        inc_idx    = 1'b0;
        abort_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_Start && !i_Abort) begin
                    start_acc = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (i_TX_Ready) begin
                    fire      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: state_nxt = (byte_cnt != '0) ? ST_SEND : ST_WAIT_RDY;
            ST_WAIT_RDY: begin
                if (i_TX_Ready) begin
                    gap_start = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // Completing the last register takes priority over a pending abort.
                if (gap_expired) begin
                    if (last_reg) begin
                        state_nxt = ST_DONE;
                    end else if (abort_flag) begin
                        abort_done = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        inc_idx   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= ST_IDLE;
            index      <= '0;
            shift      <= '0;
            byte_cnt   <= '0;
            o_TX_Byte  <= '0;
            o_TX_DV    <= 1'b0;
            o_Aborted  <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_TX_DV   <= fire;
            o_Aborted <= abort_done;
            if (start_acc) begin
                index <= '0;
            end else if (inc_idx) begin
                index <= index + IDX_W'(1);
            end
            if (load) begin
                shift    <= i_Reg_Data;
                byte_cnt <= BC_W'(BYTES_PER_REG);
            end else if (fire) begin
                shift     <= shift << BYTE_W;
                byte_cnt  <= byte_cnt - BC_W'(1);
                o_TX_Byte <= shift[DATA_W-1 -: BYTE_W];
            end
            if (start_acc || abort_done || state == ST_DONE) begin
                abort_flag <= 1'b0;
            end else if (i_Abort && state != ST_IDLE) begin
                abort_flag <= 1'b1;
            end
        end
    end

`ifdef SPI_SEQ_RX_CAPTURE_EN
    logic [DATA_W-1:0] capture;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            capture    <= '0;
            o_RX_Word  <= '0;
            o_RX_Valid <= 1'b0;
        end else begin
            o_RX_Valid <= gap_start;
            if (gap_start) begin
                o_RX_Word <= capture;
            end
            if (load) begin
                capture <= '0;
            end else if (i_RX_DV) begin
                capture <= (capture << BYTE_W) | DATA_W'(i_RX_Byte);
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: nominal, abort, busy start, reset, slow ready.
// Instance 0 uses GAP_CLKS=4 with a fast master; instance 1 uses GAP_CLKS=0 with a slow master.
module tb_spi_reg_sequencer;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    logic [1:0] start = '0;
    logic abort = 1'b0;

    logic [1:0]       busy, done, aborted, dv, rdy;
    logic [1:0][1:0]  addr, txc;
    logic [1:0][23:0] rdata;
    logic [1:0][7:0]  txb;

    logic [23:0] tbl [3] = '{24'h123456, 24'hABCDEF, 24'h000001};
    logic [7:0] exp_bytes [9] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h01};
    int exp_frame [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

    logic [7:0] byte_q [2][$];
    int frame_q [2][$];
    int rem [2], nb [2], frames [2];
    int last_dv [2] = '{-100, -100};
    logic [1:0] endf;
    int dv_cnt [2], nrdy_bad [2], space_bad [2], rdy_rise [2];
    int done_cnt [2], abort_cnt [2], txc_bad [2];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

`ifdef SPI_SEQ_RX_CAPTURE_EN
    logic [1:0]       rx_dv, rx_d1, rxv;
    logic [1:0][7:0]  rx_byte;
    logic [1:0][23:0] rx_word;
    logic [23:0] rx_q [2][$];
    int rxv_cnt [2];
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_sequencer #(
        .NUM_REGS(3), .BYTES_PER_REG(3), .MAX_BYTES_PER_CS(3), .GAP_CLKS(4)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start[0]), .i_Abort(abort),
        .o_Busy(busy[0]), .o_Done(done[0]), .o_Aborted(aborted[0]),
        .o_Reg_Addr(addr[0]), .i_Reg_Data(rdata[0]), .o_TX_Count(txc[0]),
        .o_TX_Byte(txb[0]), .o_TX_DV(dv[0]), .i_TX_Ready(rdy[0])
`ifdef SPI_SEQ_RX_CAPTURE_EN
        , .i_RX_DV(rx_dv[0]), .i_RX_Byte(rx_byte[0]), .o_RX_Word(rx_word[0]), .o_RX_Valid(rxv[0])
`endif
    );

    spi_reg_sequencer #(
        .NUM_REGS(3), .BYTES_PER_REG(3), .MAX_BYTES_PER_CS(3), .GAP_CLKS(0)
    ) dut_slow (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start[1]), .i_Abort(1'b0),
        .o_Busy(busy[1]), .o_Done(done[1]), .o_Aborted(aborted[1]),
        .o_Reg_Addr(addr[1]), .i_Reg_Data(rdata[1]), .o_TX_Count(txc[1]),
        .o_TX_Byte(txb[1]), .o_TX_DV(dv[1]), .i_TX_Ready(rdy[1])
`ifdef SPI_SEQ_RX_CAPTURE_EN
        , .i_RX_DV(rx_dv[1]), .i_RX_Byte(rx_byte[1]), .o_RX_Word(rx_word[1]), .o_RX_Valid(rxv[1])
`endif
    );

    // Table with one-cycle read latency.
    always @(posedge clk)
        for (int k = 0; k < 2; k++) rdata[k] <= (addr[k] < 2'd3) ? tbl[addr[k]] : 24'h0;

    // SPI CS master model: ready drops after each DV; CS releases before ready returns at frame end.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rdy  <= '1;
            endf <= '0;
            for (int k = 0; k < 2; k++) begin
                rem[k] <= 0;
                nb[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (dv[k] === 1'b1) begin
                    byte_q[k].push_back(txb[k]);
                    frame_q[k].push_back(frames[k]);
                    dv_cnt[k] <= dv_cnt[k] + 1;
                    if (rdy[k] !== 1'b1) nrdy_bad[k] <= nrdy_bad[k] + 1;
                    if (cyc - last_dv[k] < 2) space_bad[k] <= space_bad[k] + 1;
                    last_dv[k] <= cyc;
                    rdy[k] <= 1'b0;
                    if (nb[k] + 1 == int'(txc[k])) begin
                        endf[k] <= 1'b1;
                        nb[k]   <= 0;
                        rem[k]  <= (k == 1) ? 50 : 8;
                    end else begin
                        nb[k]  <= nb[k] + 1;
                        rem[k] <= (k == 1) ? 50 : 4;
                    end
                end else if (rem[k] > 0) begin
                    rem[k] <= rem[k] - 1;
                    if (endf[k] && rem[k] == 3) frames[k] <= frames[k] + 1;
                    if (rem[k] == 1) begin
                        rdy[k]      <= 1'b1;
                        endf[k]     <= 1'b0;
                        rdy_rise[k] <= rdy_rise[k] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_l) begin
            for (int k = 0; k < 2; k++) begin
                if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
                if (aborted[k] === 1'b1) abort_cnt[k] <= abort_cnt[k] + 1;
                if (txc[k] !== 2'd3) txc_bad[k] <= txc_bad[k] + 1;
`ifdef SPI_SEQ_RX_CAPTURE_EN
                if (rxv[k] === 1'b1) begin
                    rx_q[k].push_back(rx_word[k]);
                    rxv_cnt[k] <= rxv_cnt[k] + 1;
                end
`endif
            end
        end
    end

`ifdef SPI_SEQ_RX_CAPTURE_EN
    function automatic logic [7:0] miso(input logic [7:0] t);
        case (t)
            8'hAB:   return 8'hA5;
            8'hCD:   return 8'h5A;
            8'hEF:   return 8'hC3;
            default: return ~t;
        endcase
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rx_d1   <= '0;
            rx_dv   <= '0;
            rx_byte <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rx_d1[k] <= dv[k];
                rx_dv[k] <= rx_d1[k];
                if (dv[k] === 1'b1) rx_byte[k] <= miso(txb[k]);
            end
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_byte(input int k, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (dv[k] === 1'b1 && txb[k] === b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // sel 0 waits for a done pulse, sel 1 for an aborted pulse.
    task automatic wait_evt(input int k, input int sel, input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel == 0 ? done_cnt[k] : abort_cnt[k]) != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #13;
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        n_checks++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done[0]); end
        n_checks++; if (aborted[0] !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b want 0", aborted[0]); end
        n_checks++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dv[0]); end
        n_checks++; if (txb[0] !== 8'h00) begin n_fail++; $display("FAIL reset_txbyte: got %h want 00", txb[0]); end
        n_checks++; if (addr[0] !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr[0]); end
        n_checks++; if (txc[0] !== 2'd3) begin n_fail++; $display("FAIL reset_txcount: got %0d want 3", txc[0]); end
        @(negedge clk);
        rst_l = 1'b1;
        repeat (4) tick();
        n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL idle_busy: got %b want 00", busy); end
    endtask

    task automatic test_nominal();
        int b, d, a, lat, f0;
        bit ok;
        b = byte_q[0].size();
        d = done_cnt[0];
        a = abort_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_checks++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy[0]); end
        n_checks++; if (addr[0] !== 2'd0) begin n_fail++; $display("FAIL start_addr: got %0d want 0", addr[0]); end
        lat = 0;
        while (dv[0] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL first_dv_latency: got %0d want 3", lat); end
        wait_evt(0, 0, d, 2000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL nominal_done_timeout: got %b want 1", ok); end
        repeat (5) tick();
        n_checks++; if (byte_q[0].size() - b !== 9) begin n_fail++; $display("FAIL nominal_nbytes: got %0d want 9", byte_q[0].size() - b); end
        f0 = (byte_q[0].size() > b) ? frame_q[0][b] : 0;
        for (int i = 0; i < 9; i++) begin
            n_checks++; if (byte_q[0][b+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL nominal_byte%0d: got %h want %h", i, byte_q[0][b+i], exp_bytes[i]); end
            n_checks++; if (frame_q[0][b+i] - f0 !== exp_frame[i]) begin n_fail++; $display("FAIL nominal_frame%0d: got %0d want %0d", i, frame_q[0][b+i] - f0, exp_frame[i]); end
        end
        n_checks++; if (done_cnt[0] - d !== 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d want 1", done_cnt[0] - d); end
        n_checks++; if (abort_cnt[0] - a !== 0) begin n_fail++; $display("FAIL nominal_abort_count: got %0d want 0", abort_cnt[0] - a); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_after: got %b want 0", busy[0]); end
        n_checks++; if (txb[0] !== 8'h01) begin n_fail++; $display("FAIL nominal_txbyte_hold: got %h want 01", txb[0]); end
        n_checks++; if (txc_bad[0] !== 0) begin n_fail++; $display("FAIL nominal_txcount: got %0d bad cycles want 0", txc_bad[0]); end
        n_checks++; if (space_bad[0] !== 0) begin n_fail++; $display("FAIL nominal_dv_spacing: got %0d want 0", space_bad[0]); end
        n_checks++; if (nrdy_bad[0] !== 0) begin n_fail++; $display("FAIL nominal_dv_not_ready: got %0d want 0", nrdy_bad[0]); end
`ifdef SPI_SEQ_RX_CAPTURE_EN
        n_checks++; if (rx_q[0].size() !== 3) begin n_fail++; $display("FAIL rx_valid_count: got %0d want 3", rx_q[0].size()); end
        n_checks++; if (rx_q[0][0] !== 24'hEDCBA9) begin n_fail++; $display("FAIL rx_word0: got %h want EDCBA9", rx_q[0][0]); end
        n_checks++; if (rx_q[0][1] !== 24'hA55AC3) begin n_fail++; $display("FAIL rx_word1: got %h want A55AC3", rx_q[0][1]); end
        n_checks++; if (rx_q[0][2] !== 24'hFFFFFE) begin n_fail++; $display("FAIL rx_word2: got %h want FFFFFE", rx_q[0][2]); end
`endif
    endtask

    task automatic test_abort();
        int b, d, a;
        bit ok;
        b = byte_q[0].size();
        d = done_cnt[0];
        a = abort_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_byte(0, 8'h34, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_byte2_timeout: got %b want 1", ok); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_evt(0, 1, a, 500, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abort_timeout: got %b want 1", ok); end
        repeat (40) tick();
        n_checks++; if (byte_q[0].size() - b !== 3) begin n_fail++; $display("FAIL abort_nbytes: got %0d want 3", byte_q[0].size() - b); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (byte_q[0][b+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL abort_byte%0d: got %h want %h", i, byte_q[0][b+i], exp_bytes[i]); end
        end
        n_checks++; if (abort_cnt[0] - a !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d want 1", abort_cnt[0] - a); end
        n_checks++; if (done_cnt[0] - d !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d want 0", done_cnt[0] - d); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
    endtask

    task automatic test_start_busy();
        int b, d;
        bit ok;
        b = byte_q[0].size();
        d = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (15) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_evt(0, 0, d, 2000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_start_done_timeout: got %b want 1", ok); end
        repeat (5) tick();
        n_checks++; if (byte_q[0].size() - b !== 9) begin n_fail++; $display("FAIL busy_start_nbytes: got %0d want 9", byte_q[0].size() - b); end
        n_checks++; if (done_cnt[0] - d !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt[0] - d); end
        @(negedge clk);
        start[0] = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        abort    = 1'b0;
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b want 0", busy[0]); end
        repeat (10) tick();
        n_checks++; if (byte_q[0].size() - b !== 9) begin n_fail++; $display("FAIL start_abort_nbytes: got %0d want 9", byte_q[0].size() - b); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy_late: got %b want 0", busy[0]); end
    endtask

    task automatic test_reset_midframe();
        int b, d;
        bit ok;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_byte(0, 8'h34, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midreset_byte2_timeout: got %b want 1", ok); end
        rst_l = 1'b0;
        #1;
        n_checks++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_dv: got %b want 0", dv[0]); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
        n_checks++; if (txb[0] !== 8'h00) begin n_fail++; $display("FAIL midreset_txbyte: got %h want 00", txb[0]); end
        n_checks++; if (addr[0] !== 2'd0) begin n_fail++; $display("FAIL midreset_addr: got %0d want 0", addr[0]); end
        n_checks++; if (aborted[0] !== 1'b0 || done[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: got %b%b want 00", done[0], aborted[0]); end
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) tick();
        b = byte_q[0].size();
        d = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_evt(0, 0, d, 2000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL restart_done_timeout: got %b want 1", ok); end
        n_checks++; if (byte_q[0].size() - b !== 9) begin n_fail++; $display("FAIL restart_nbytes: got %0d want 9", byte_q[0].size() - b); end
        n_checks++; if (byte_q[0][b] !== 8'h12) begin n_fail++; $display("FAIL restart_first_byte: got %h want 12", byte_q[0][b]); end
        n_checks++; if (byte_q[0][b+8] !== 8'h01) begin n_fail++; $display("FAIL restart_last_byte: got %h want 01", byte_q[0][b+8]); end
    endtask

    task automatic test_slow_ready();
        int b, d, ndv, nrise, f0;
        bit ok;
        b     = byte_q[1].size();
        d     = done_cnt[1];
        ndv   = dv_cnt[1];
        nrise = rdy_rise[1];
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_evt(1, 0, d, 3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL slow_done_timeout: got %b want 1", ok); end
        repeat (3) tick();
        n_checks++; if (byte_q[1].size() - b !== 9) begin n_fail++; $display("FAIL slow_nbytes: got %0d want 9", byte_q[1].size() - b); end
        f0 = (byte_q[1].size() > b) ? frame_q[1][b] : 0;
        for (int i = 0; i < 9; i++) begin
            n_checks++; if (byte_q[1][b+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL slow_byte%0d: got %h want %h", i, byte_q[1][b+i], exp_bytes[i]); end
            n_checks++; if (frame_q[1][b+i] - f0 !== exp_frame[i]) begin n_fail++; $display("FAIL slow_frame%0d: got %0d want %0d", i, frame_q[1][b+i] - f0, exp_frame[i]); end
        end
        n_checks++; if (nrdy_bad[1] !== 0) begin n_fail++; $display("FAIL slow_dv_not_ready: got %0d want 0", nrdy_bad[1]); end
        n_checks++; if (space_bad[1] !== 0) begin n_fail++; $display("FAIL slow_dv_spacing: got %0d want 0", space_bad[1]); end
        n_checks++; if (dv_cnt[1] - ndv !== rdy_rise[1] - nrise) begin n_fail++; $display("FAIL slow_dv_per_ready: got %0d dv want %0d", dv_cnt[1] - ndv, rdy_rise[1] - nrise); end
        n_checks++; if (done_cnt[1] - d !== 1) begin n_fail++; $display("FAIL slow_done_count: got %0d want 1", done_cnt[1] - d); end
        n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL slow_busy_after: got %b want 0", busy[1]); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_abort();
        test_start_busy();
        test_reset_midframe();
        test_slow_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
